// File: rtl/led_share_pkg.sv
// Shared definitions for the LED share arbiter: FSM state encodings and a
// constant-evaluable ceil(log2) helper used for counter and index widths.
package led_share_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit found cyclically
// starting just after the previous grantee.
module rr_pick #(
   parameter int NREQ = 2,
   parameter int IW   = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic            valid,
   output logic [IW-1:0]   index
);

   logic [IW-1:0] cand;

   // Walk from the farthest candidate to the nearest so the nearest hit wins.
   always_comb begin
      valid = 1'b0;
      index = '0;
      cand  = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = IW'((int'(last) + k) % NREQ);
         if (req[cand]) begin
            valid = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/led_share_arbiter.sv
// Shares one LED gate between NREQ requesters: round-robin grant, fixed hold
// time, guard gap between grants, and a global inhibit that forces release.
module led_share_arbiter
   import led_share_pkg::*;
#(
   parameter int NREQ        = 2,
   parameter int HOLD_CYCLES = 25000000,
   parameter int GAP_CYCLES  = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inhibit,
   input  logic [NREQ-1:0]          req,
   output logic [NREQ-1:0]          gnt,
   output logic [clog2(NREQ)-1:0]   owner,
   output logic                     led_,
   output logic                     done
);

   localparam int OW    = clog2(NREQ);
   localparam int CNT_W = clog2(((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   logic [1:0]      state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [NREQ-1:0] gnt_reg;
   logic [OW-1:0]   owner_reg;
   logic [OW-1:0]   last_reg;
   logic            led_reg;
   logic            done_reg;

   logic            pick_valid;
   logic [OW-1:0]   pick_index;
   logic [NREQ-1:0] pick_onehot;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (OW)
   ) u_pick (
      .req   (req),
      .last  (last_reg),
      .valid (pick_valid),
      .index (pick_index)
   );

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick_index == OW'(gi));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         gnt_reg   <= '0;
         owner_reg <= '0;
         last_reg  <= OW'(NREQ - 1);
         led_reg   <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (!inhibit && pick_valid) begin
                  gnt_reg   <= pick_onehot;
                  owner_reg <= pick_index;
                  led_reg   <= 1'b1;
                  cnt_reg   <= '0;
                  state_reg <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               // Any termination advances last so peers rotate fairly.
               if (inhibit) begin
                  gnt_reg   <= '0;
                  led_reg   <= 1'b0;
                  last_reg  <= owner_reg;
                  cnt_reg   <= '0;
                  state_reg <= ST_IDLE;
               end else if (!req[owner_reg]) begin
                  gnt_reg   <= '0;
                  led_reg   <= 1'b0;
                  last_reg  <= owner_reg;
                  cnt_reg   <= '0;
                  state_reg <= ST_GAP;
               end else if (cnt_reg == HOLD_LAST) begin
                  gnt_reg   <= '0;
                  led_reg   <= 1'b0;
                  done_reg  <= 1'b1;
                  last_reg  <= owner_reg;
                  cnt_reg   <= '0;
                  state_reg <= ST_GAP;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt_reg == GAP_LAST) begin
                  cnt_reg   <= '0;
                  state_reg <= ST_IDLE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               cnt_reg   <= '0;
               gnt_reg   <= '0;
               led_reg   <= 1'b0;
            end
         endcase
      end
   end

   assign gnt   = gnt_reg;
   assign owner = owner_reg;
   assign led_  = led_reg;
   assign done  = done_reg;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Self-checking bench for led_share_arbiter (NREQ=2, HOLD=4, GAP=1): directed
// scenarios plus random stimulus against a timer-based reference model.
module tb_led_share_arbiter;

   localparam int NREQ = 2;
   localparam int HOLD = 4;
   localparam int GAP  = 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            inhibit;
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] gnt;
   logic [0:0]      owner;
   logic            led_;
   logic            done;

   int total = 0;
   int bad   = 0;

   // Reference model: who holds the LED, how many cycles it has been lit,
   // how many guard cycles remain, and who was served last.
   int m_own  = -1;
   int m_lit  = 0;
   int m_gap  = 0;
   int m_last = NREQ - 1;
   int m_disp = 0;
   bit m_done = 1'b0;

   led_share_arbiter #(
      .NREQ        (NREQ),
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (GAP)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .inhibit (inhibit),
      .req     (req),
      .gnt     (gnt),
      .owner   (owner),
      .led_    (led_),
      .done    (done)
   );

   always #5 clk = ~clk;

   function automatic void model_edge();
      bit found;
      m_done = 1'b0;
      if (rst) begin
         m_own = -1; m_lit = 0; m_gap = 0; m_last = NREQ - 1; m_disp = 0;
      end else if (m_own >= 0) begin
         if (inhibit) begin
            m_last = m_own; m_own = -1; m_gap = 0;
         end else if (!req[m_own]) begin
            m_last = m_own; m_own = -1; m_gap = GAP;
         end else if (m_lit == HOLD) begin
            m_last = m_own; m_own = -1; m_gap = GAP; m_done = 1'b1;
         end else begin
            m_lit++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (!inhibit) begin
         found = 1'b0;
         for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(m_last + k) % NREQ]) begin
               found = 1'b1;
               m_own = (m_last + k) % NREQ;
               m_disp = m_own;
               m_lit = 1;
            end
         end
      end
   endfunction

   function automatic logic [NREQ-1:0] m_gnt();
      logic [NREQ-1:0] one;
      one = 1;
      return (m_own >= 0) ? (one << m_own) : '0;
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; inhibit = 1'b0; req = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      req = 2'b11;
      rst = 1'b1;
      step();
      step();
      total++;
      if (gnt !== 2'b00 || led_ !== 1'b0 || done !== 1'b0 || owner !== 1'b0) begin
         bad++;
         $display("FAIL reset gnt=%b led=%b done=%b owner=%0d want 00/0/0/0", gnt, led_, done, owner);
      end
      rst = 1'b0; req = '0;
   endtask

   task automatic test_single();
      logic [1:0] eg;
      logic       ed;
      do_reset();
      req = 2'b01;
      for (int c = 1; c <= 13; c++) begin
         step();
         eg = (((c - 1) % 6) < 4) ? 2'b01 : 2'b00;
         ed = (((c - 1) % 6) == 4);
         total++;
         if (gnt !== eg || led_ !== eg[0] || done !== ed) begin
            bad++;
            $display("FAIL single c=%0d gnt=%b led=%b done=%b want %b/%b/%b", c, gnt, led_, done, eg, eg[0], ed);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] eg;
      do_reset();
      req = 2'b11;
      for (int c = 1; c <= 25; c++) begin
         step();
         if (((c - 1) % 6) < 4) eg = (((c - 1) / 6) % 2 == 0) ? 2'b01 : 2'b10;
         else                   eg = 2'b00;
         total++;
         if (gnt !== eg || done !== (((c - 1) % 6) == 4) || owner !== 1'(((c - 1) / 6) % 2)) begin
            bad++;
            $display("FAIL round_robin c=%0d gnt=%b done=%b owner=%0d want gnt=%b", c, gnt, done, owner, eg);
         end
      end
   endtask

   task automatic test_inhibit_abort();
      do_reset();
      req = 2'b11;
      step();
      step();
      inhibit = 1'b1;
      for (int c = 3; c <= 8; c++) begin
         step();
         total++;
         if (gnt !== 2'b00 || led_ !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL inhibit_abort c=%0d gnt=%b led=%b done=%b want 00/0/0", c, gnt, led_, done);
         end
      end
      inhibit = 1'b0;
      step();
      total++;
      if (gnt !== 2'b10 || owner !== 1'b1) begin
         bad++;
         $display("FAIL inhibit_next gnt=%b owner=%0d want 10/1", gnt, owner);
      end
   endtask

   task automatic test_early_release();
      do_reset();
      req = 2'b01;
      step();
      step();
      req = 2'b00;
      step();
      total++;
      if (gnt !== 2'b00 || led_ !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL early_release gnt=%b led=%b done=%b want 00/0/0", gnt, led_, done);
      end
      req = 2'b01;
      step();
      total++;
      if (gnt !== 2'b00 || done !== 1'b0) begin
         bad++;
         $display("FAIL early_gap gnt=%b done=%b want 00/0", gnt, done);
      end
      step();
      total++;
      if (gnt !== 2'b01) begin
         bad++;
         $display("FAIL early_regrant gnt=%b want 01", gnt);
      end
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      req = 2'b10;
      step();
      total++;
      if (gnt !== 2'b10) begin
         bad++;
         $display("FAIL rst_mid_first gnt=%b want 10", gnt);
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if (gnt !== 2'b00 || led_ !== 1'b0 || done !== 1'b0 || owner !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid gnt=%b led=%b done=%b owner=%0d want 00/0/0/0", gnt, led_, done, owner);
      end
      req = 2'b11;
      step();
      total++;
      if (gnt !== 2'b01) begin
         bad++;
         $display("FAIL rst_mid_regrant gnt=%b want 01", gnt);
      end
   endtask

   task automatic test_inhibit_long();
      do_reset();
      inhibit = 1'b1;
      req = 2'b11;
      for (int c = 1; c <= 20; c++) begin
         step();
         total++;
         if (gnt !== 2'b00 || led_ !== 1'b0) begin
            bad++;
            $display("FAIL inhibit_long c=%0d gnt=%b led=%b want 00/0", c, gnt, led_);
         end
      end
      inhibit = 1'b0;
      step();
      total++;
      if (gnt !== 2'b01 || led_ !== 1'b1) begin
         bad++;
         $display("FAIL inhibit_release gnt=%b led=%b want 01/1", gnt, led_);
      end
   endtask

   task automatic test_random();
      bit prev_done;
      do_reset();
      prev_done = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) req = 2'($urandom);
         inhibit = ($urandom_range(0, 15) == 0);
         rst     = ($urandom_range(0, 199) == 0);
         step();
         total++;
         if (gnt !== m_gnt() || led_ !== (m_own >= 0) || done !== m_done || owner !== 1'(m_disp)) begin
            bad++;
            $display("FAIL random c=%0d gnt=%b led=%b done=%b owner=%0d want %b/%b/%b/%0d",
                     c, gnt, led_, done, owner, m_gnt(), (m_own >= 0), m_done, m_disp);
         end
         total++;
         if (done && prev_done) begin
            bad++;
            $display("FAIL done_twice c=%0d done=%b prev=%b want not both 1", c, done, prev_done);
         end
         prev_done = done;
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; inhibit = 1'b0; req = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_inhibit_abort();
      test_early_release();
      test_reset_mid_hold();
      test_inhibit_long();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/led_share_arbiter.md
Name: led_share_arbiter

Overview:
Round-robin arbiter and hold-timer controller that shares the single board LED gate between NREQ switch requesters.
- Grants one requester at a time and holds the LED on for a fixed number of cycles.
- Inserts a guard gap between grants.
- Honours a global inhibit input: the LED is on only when inhibit is low, the equivalent of led_ = ~c & d at the gate.
- Sits between the debounced switch inputs and the LED pin in the lab top level.

Parameters:
NREQ, 2, number of requesters (2..8)
HOLD_CYCLES, 25000000, clock cycles a grant holds the LED on (>=1; 0.5 s at 50 MHz)
GAP_CYCLES, 1, idle guard cycles after each grant ends (>=1)
CNT_W, derived, clog2(max(HOLD_CYCLES,GAP_CYCLES)+1), counter width (localparam)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
inhibit  in  1  global LED inhibit (the c role); 1 forces release and blocks new grants
req  in  NREQ  request per requester (the d role), level-sensitive
gnt  out  NREQ  one-hot grant, registered; all zero when idle
owner  out  clog2(NREQ)  index of the current or last grantee, registered
led_  out  1  LED drive, registered; 1 exactly when gnt != 0
done  out  1  one-cycle pulse when a grant completes its full HOLD_CYCLES

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, gnt=0, led_=0, done=0, owner=0, cnt=0, last=NREQ-1 (so requester 0 wins first).
- States: IDLE, HOLD, GAP. Encoding is 2-bit, binary.
- IDLE:
  - If inhibit=0 and req!=0 at an edge: pick the first set req bit, searching cyclically from last+1.
  - At that edge: gnt=onehot(pick), owner=pick, led_=1, cnt=0, state=HOLD.
  - Latency: req sampled at edge k produces gnt and led_ visible after edge k (one cycle).
- HOLD, checked each edge in priority order:
  - 1. inhibit=1: gnt=0, led_=0, state=IDLE, last=owner, no done.
  - 2. req[owner]=0: gnt=0, led_=0, state=GAP, cnt=0, last=owner, no done (early release).
  - 3. cnt==HOLD_CYCLES-1: gnt=0, led_=0, done=1 (for this one cycle), state=GAP, cnt=0, last=owner.
  - 4. Otherwise: cnt+1.
  - Result: gnt is high for exactly HOLD_CYCLES cycles on full expiry.
- GAP:
  - gnt=0 throughout; done clears after one cycle.
  - cnt increments; at cnt==GAP_CYCLES-1, state=IDLE.
  - inhibit has no effect in GAP.
  - A new grant can occur at the first IDLE edge, so the minimum gnt-low time between grants is GAP_CYCLES+1 cycles.
- Inhibit and req rising in the same IDLE cycle: no grant. Inhibit always wins.
- Round robin: last advances on every grant termination (expiry, early release or inhibit abort), so a continuously requesting peer is never starved.
- Requests from non-owners during HOLD/GAP are ignored; they are only evaluated in IDLE.
- rst mid-HOLD: outputs return to reset values at that edge; no done is emitted.
- Invariants:
  - gnt is always one-hot or zero.
  - led_ == |gnt.
  - done is never high in two consecutive cycles.
- Counter: unsigned CNT_W bits, never wraps (always reset before its terminal value).

Decomposition:
- Shared package led_share_pkg:
  - state encodings (ST_IDLE=0, ST_HOLD=1, ST_GAP=2);
  - clog2 function for CNT_W and owner width.
- One natural sub-module, rr_pick: a purely combinational round-robin picker.
  - Inputs: req, last.
  - Outputs: valid, index.
  - Instantiated once.
- FSM, counter and output registers stay in led_share_arbiter.

Test Plan:
All scenarios use NREQ=2, HOLD_CYCLES=4, GAP_CYCLES=1.
- 1. Reset, then req=01 held from cycle 0 -> gnt=01 and led_=1 for cycles 1..4; done=1 in cycle 5 only; gnt=00 in cycles 5..6; gnt=01 again from cycle 7.
- 2. req=11 held continuously -> gnt sequence 01(x4), 00(x2), 10(x4), 00(x2), 01 ...; owner alternates 0,1,0; done pulses once per grant.
- 3. req=11, inhibit=1 asserted in the 2nd HOLD cycle -> gnt=00 and led_=0 the next cycle; no done; while inhibit=1, gnt stays 00; inhibit=0 -> next grant is 10.
- 4. req=01 dropped to 00 after 2 HOLD cycles -> gnt=00 the next cycle; done stays 0; state passes through GAP then IDLE.
- 5. rst pulsed for one cycle mid-HOLD with req=10 -> all outputs 0 after the edge; then req=11 -> first grant is 01.
- 6. inhibit=1 with req=11 for 20 cycles -> gnt=00 and led_=0 throughout; inhibit drops at cycle 20 -> gnt=01 visible in cycle 21.
